// File: rtl/parity_class_tracker.sv
// Tracks the parity class (even/odd) of an accepted sample stream: current class,
// run length of the current class, a change pulse, and per-class saturating totals.
module parity_class_tracker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RUN_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  input  logic              clear,
  output logic              even,
  output logic              odd,
  output logic              seen,
  output logic [RUN_W-1:0]  run_len,
  output logic              changed,
  output logic [CNT_W-1:0]  even_total,
  output logic [CNT_W-1:0]  odd_total
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVEN = 2'd1;
  localparam logic [1:0] ODD  = 2'd2;

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;

  logic             sample_cls;
  logic [1:0]       sample_state;
  logic             same_class;

  // Class of the presented sample: LSB or full XOR-reduction, selected per sample.
  always_comb begin
    sample_cls   = mode ? (^data_in) : data_in[0];
    sample_state = sample_cls ? ODD : EVEN;
    same_class   = (state_q == sample_state);
  end

  // Next-state and counter update; clear outranks any sample in the same cycle.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    changed_d  = 1'b0;
    even_cnt_d = even_cnt_q;
    odd_cnt_d  = odd_cnt_q;

    if (clear) begin
      state_d    = IDLE;
      run_d      = '0;
      even_cnt_d = '0;
      odd_cnt_d  = '0;
    end else if (in_valid) begin
      state_d = sample_state;

      if ((state_q == IDLE) || !same_class) begin
        run_d     = RUN_W'(1);
        changed_d = (state_q != IDLE);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end

      if (sample_cls) begin
        if (odd_cnt_q != CNT_MAX) begin
          odd_cnt_d = odd_cnt_q + CNT_W'(1);
        end
      end else begin
        if (even_cnt_q != CNT_MAX) begin
          even_cnt_d = even_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      run_q      <= '0;
      changed_q  <= 1'b0;
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      changed_q  <= changed_d;
      even_cnt_q <= even_cnt_d;
      odd_cnt_q  <= odd_cnt_d;
    end
  end

  // Class flags are pure decodes of the state register.
  assign even       = (state_q == EVEN);
  assign odd        = (state_q == ODD);
  assign seen       = (state_q != IDLE);
  assign run_len    = run_q;
  assign changed    = changed_q;
  assign even_total = even_cnt_q;
  assign odd_total  = odd_cnt_q;

endmodule

// File: tb/tb_parity_class_tracker.sv
// Scoreboard bench for parity_class_tracker: a default-parameter instance and a
// narrow instance (DATA_W=1, RUN_W=2, CNT_W=2) share one stimulus stream.
module tb_parity_class_tracker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] data_in;
  logic [0:0] data_in1;
  logic       mode;
  logic       clear;

  logic        even, odd, seen, changed;
  logic [3:0]  run_len;
  logic [15:0] even_total, odd_total;

  logic        s_even, s_odd, s_seen, s_changed;
  logic [1:0]  s_run_len;
  logic [1:0]  s_even_total, s_odd_total;

  parity_class_tracker u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .mode       (mode),
    .clear      (clear),
    .even       (even),
    .odd        (odd),
    .seen       (seen),
    .run_len    (run_len),
    .changed    (changed),
    .even_total (even_total),
    .odd_total  (odd_total)
  );

  parity_class_tracker #(.DATA_W(1), .RUN_W(2), .CNT_W(2)) u_small (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_in    (data_in1),
    .mode       (mode),
    .clear      (clear),
    .even       (s_even),
    .odd        (s_odd),
    .seen       (s_seen),
    .run_len    (s_run_len),
    .changed    (s_changed),
    .even_total (s_even_total),
    .odd_total  (s_odd_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st, run, chg, et, ot;
    int sst, srun, schg, set_, sot;
  } exp_t;

  exp_t exp_q[$];

  int n_checks;
  int n_errors;

  // model state: st 0=IDLE 1=EVEN 2=ODD
  int m_st, m_run, m_chg, m_et, m_ot;
  int s_st, s_run, s_chg, s_et, s_ot;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit clr, input bit c,
                            input int rmax, input int cmax,
                            inout int st, inout int run, inout int chg,
                            inout int et, inout int ot);
    int nst;
    if (clr) begin
      st = 0; run = 0; chg = 0; et = 0; ot = 0;
    end else if (v) begin
      nst = c ? 2 : 1;
      if (st == 0 || st != nst) begin
        chg = (st != 0) ? 1 : 0;
        run = 1;
      end else begin
        chg = 0;
        if (run < rmax) run = run + 1;
      end
      if (c) begin
        if (ot < cmax) ot = ot + 1;
      end else begin
        if (et < cmax) et = et + 1;
      end
      st = nst;
    end else begin
      chg = 0;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_chg = 0; m_et = 0; m_ot = 0;
    s_st = 0; s_run = 0; s_chg = 0; s_et = 0; s_ot = 0;
  endtask

  task automatic compare(input exp_t e);
    chk("even",        even,         e.st == 1);
    chk("odd",         odd,          e.st == 2);
    chk("seen",        seen,         e.st != 0);
    chk("run_len",     run_len,      e.run);
    chk("changed",     changed,      e.chg);
    chk("even_total",  even_total,   e.et);
    chk("odd_total",   odd_total,    e.ot);
    chk("s_even",      s_even,       e.sst == 1);
    chk("s_odd",       s_odd,        e.sst == 2);
    chk("s_seen",      s_seen,       e.sst != 0);
    chk("s_run_len",   s_run_len,    e.srun);
    chk("s_changed",   s_changed,    e.schg);
    chk("s_even_tot",  s_even_total, e.set_);
    chk("s_odd_tot",   s_odd_total,  e.sot);
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.st = m_st; e.run = m_run; e.chg = m_chg; e.et = m_et; e.ot = m_ot;
    e.sst = s_st; e.srun = s_run; e.schg = s_chg; e.set_ = s_et; e.sot = s_ot;
    return e;
  endfunction

  // Drive one cycle, push the model's prediction, then pop and check after the edge.
  task automatic drive(input bit v, input logic [7:0] d, input bit m, input bit clr);
    bit c;
    exp_t e;
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    data_in1 = d[0];
    mode     = m;
    clear    = clr;
    c = m ? (^d) : d[0];
    model_step(v, clr, c, 15, 65535, m_st, m_run, m_chg, m_et, m_ot);
    model_step(v, clr, d[0], 3, 3, s_st, s_run, s_chg, s_et, s_ot);
    exp_q.push_back(snapshot());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      compare(e);
    end
  endtask

  initial begin
    exp_t z;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    data_in1 = '0;
    mode     = 1'b0;
    clear    = 1'b0;
    model_reset();
    z = snapshot();

    // Outputs must be zero while reset is held, before any clock edge.
    #1;
    compare(z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic stream with LSB classification.
    drive(1, 8'h04, 0, 0);
    drive(1, 8'h06, 0, 0);
    drive(1, 8'h03, 0, 0);
    // Idle cycle: state holds, changed drops.
    drive(0, 8'h00, 0, 0);

    // XOR mode vs LSB mode on the same data.
    drive(1, 8'h03, 1, 0);
    drive(1, 8'h03, 0, 0);
    // Mode flip without a sample must not reclassify.
    drive(0, 8'h03, 1, 0);
    drive(0, 8'h03, 1, 0);

    // Clear beats a simultaneous sample, taken from EVEN.
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h01, 0, 1);
    drive(0, 8'h00, 0, 0);

    // Long odd run: main saturates run_len at 15, narrow saturates run and total at 3.
    for (int i = 0; i < 20; i++) drive(1, 8'h01, 0, 0);

    // Build ODD with run_len=5, then pulse reset between edges.
    drive(1, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'h07, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    compare(snapshot());
    #1;
    reset = 1'b0;
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h02, 0, 0);

    // Narrow totals saturate at 3 on five even samples.
    drive(1, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'h00, 0, 0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 31) == 0));
    end

    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
